// File: rtl/wfc_pkg.sv
// Shared definitions for the weight fetch controller.
// WEIGHT_LOAD_EN adds the LOAD state used to write weights into the BRAM.
`timescale 1ns/1ps
package wfc_pkg;

  localparam int unsigned WFC_DEPTH = 28;
  localparam int unsigned WFC_AW    = 5;
  localparam int unsigned WFC_DW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
`ifdef WEIGHT_LOAD_EN
    ,
    ST_LOAD  = 2'd3
`endif
  } wfc_state_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry skid FIFO for weight words; entry 0 is always the head, so the
// output is taken straight from a register and stays stable while stalled.
`timescale 1ns/1ps
module weight_skid_fifo #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_valid,
  output logic [1:0]    count
);

  logic [DW-1:0] data0, data1;
  logic          last0, last1;
  logic          push_ok, pop_ok;

  assign pop_ok    = pop && (count != 2'd0);
  assign push_ok   = push && ((count != 2'd2) || pop_ok);
  assign out_data  = data0;
  assign out_valid = (count != 2'd0);
  assign out_last  = last0 && out_valid;

  // Shift-style storage: pops move entry 1 into the head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
      count <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data1 <= push_data;
            last1 <= push_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= push_data;
            last1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: streams BRAM words 0..DEPTH-1 through a 2-entry
// skid FIFO with ready/valid flow control. Defining WEIGHT_LOAD_EN adds a
// LOAD state and LD_* ports for writing the BRAM.
`timescale 1ns/1ps
module weight_fetch_ctrl
  import wfc_pkg::*;
#(
  parameter int unsigned DEPTH = WFC_DEPTH,
  parameter int unsigned AW    = WFC_AW,
  parameter int unsigned DW    = WFC_DW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] BRAM_ADDR,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  output logic [DW-1:0] BRAM_DI,
  input  logic [DW-1:0] BRAM_DO,
  output logic [DW-1:0] W_DATA,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST
`ifdef WEIGHT_LOAD_EN
  ,
  input  logic          LD_START,
  input  logic          LD_VALID,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  wfc_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] issue_addr;
  logic          issue_rd, ld_wr, done_d;
  logic          push, pop, room;
  logic [1:0]    fifo_cnt;
  logic [2:0]    occ_next;

  assign BUSY = (state_q != ST_IDLE);
  assign pop  = W_VALID && W_READY;
  // A read is in flight during every EN=1/WE=0 cycle; its data lands at the next edge.
  assign push = BRAM_EN && !BRAM_WE;

  // Words that will be buffered next cycle; a new read may only be issued
  // if that leaves space for it once it lands.
  assign occ_next = 3'(fifo_cnt) + 3'(push) - 3'(pop);
  assign room     = (occ_next < 3'd2);

`ifdef WEIGHT_LOAD_EN
  assign LD_READY = (state_q == ST_LOAD);
`endif

  // State and address counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, read issue and load write decisions. The IDLE branch issues
  // address 0 itself so the registered EN is already high in the first
  // FETCH cycle. A START/LD_START coinciding with DONE is dropped.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_rd   = 1'b0;
    issue_addr = addr_q;
    ld_wr      = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (!DONE) begin
`ifdef WEIGHT_LOAD_EN
          if (LD_START) begin
            state_d = ST_LOAD;
          end else
`endif
          if (START) begin
            issue_rd   = 1'b1;
            issue_addr = '0;
            if (DEPTH == 1) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_FETCH;
              addr_d  = AW'(1);
            end
          end
        end
      end
      ST_FETCH: begin
        if (room) begin
          issue_rd = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pop && W_LAST) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end
      end
`ifdef WEIGHT_LOAD_EN
      ST_LOAD: begin
        if (LD_VALID) begin
          ld_wr = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered BRAM enable/address and the DONE pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BRAM_EN   <= 1'b0;
      BRAM_ADDR <= '0;
      DONE      <= 1'b0;
    end else begin
      BRAM_EN <= issue_rd || ld_wr;
      DONE    <= done_d;
      if (issue_rd) begin
        BRAM_ADDR <= issue_addr;
      end else if (ld_wr) begin
        BRAM_ADDR <= addr_q;
      end else if (state_d == ST_IDLE) begin
        BRAM_ADDR <= '0;
      end
    end
  end

`ifdef WEIGHT_LOAD_EN
  // Registered write strobe and write data for the load path.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BRAM_WE <= 1'b0;
      BRAM_DI <= '0;
    end else begin
      BRAM_WE <= ld_wr;
      if (ld_wr) begin
        BRAM_DI <= LD_DATA;
      end
    end
  end
`else
  assign BRAM_WE = 1'b0;
  assign BRAM_DI = '0;
`endif

  weight_skid_fifo #(.DW(DW)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push),
    .push_data (BRAM_DO),
    .push_last (BRAM_ADDR == LAST_ADDR),
    .pop       (pop),
    .out_data  (W_DATA),
    .out_last  (W_LAST),
    .out_valid (W_VALID),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Testbench for weight_fetch_ctrl: BRAM model, table of read passes,
// reset-mid-pass sequence and (with WEIGHT_LOAD_EN) a load-then-read pass.
`timescale 1ns/1ps
module tb_weight_fetch_ctrl;

  localparam int unsigned DEPTH = 28;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0;
  logic          W_READY = 1'b0;
  logic          BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_LAST;
  logic [AW-1:0] BRAM_ADDR;
  logic [DW-1:0] BRAM_DI, W_DATA;
  logic [DW-1:0] BRAM_DO = '0;
`ifdef WEIGHT_LOAD_EN
  logic          LD_START = 1'b0;
  logic          LD_VALID = 1'b0;
  logic [DW-1:0] LD_DATA = '0;
  logic          LD_READY;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic          bram_init = 1'b1;
  logic [DW-1:0] exp_base = 16'h0100;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int mode;       // 0: ready high, 1: 1,0,0,1 pattern, 2: random, 3: stall then high
    int stall;
    bit extra;      // extra START pulses while busy and in the DONE cycle
    int exp_first;  // cycle of first W_VALID after START
    int exp_done;   // cycle of DONE after START, -1 = only relative check
  } pass_vec_t;

  pass_vec_t vecs [6];

  weight_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .BRAM_ADDR (BRAM_ADDR),
    .BRAM_EN   (BRAM_EN),
    .BRAM_WE   (BRAM_WE),
    .BRAM_DI   (BRAM_DI),
    .BRAM_DO   (BRAM_DO),
    .W_DATA    (W_DATA),
    .W_VALID   (W_VALID),
    .W_READY   (W_READY),
    .W_LAST    (W_LAST)
`ifdef WEIGHT_LOAD_EN
    ,
    .LD_START  (LD_START),
    .LD_VALID  (LD_VALID),
    .LD_DATA   (LD_DATA),
    .LD_READY  (LD_READY)
`endif
  );

  always #5 CLK = ~CLK;

  // BRAM model: acts on the falling edge; preload while bram_init is set.
  always @(negedge CLK) begin
    if (bram_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0100 + 16'(i);
    end else if (BRAM_EN) begin
      if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
      else         BRAM_DO <= mem[BRAM_ADDR];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " BUSY"},      32'(BUSY),      0);
    chk({tag, " DONE"},      32'(DONE),      0);
    chk({tag, " BRAM_EN"},   32'(BRAM_EN),   0);
    chk({tag, " BRAM_WE"},   32'(BRAM_WE),   0);
    chk({tag, " BRAM_ADDR"}, 32'(BRAM_ADDR), 0);
    chk({tag, " BRAM_DI"},   32'(BRAM_DI),   0);
    chk({tag, " W_VALID"},   32'(W_VALID),   0);
    chk({tag, " W_LAST"},    32'(W_LAST),    0);
    chk({tag, " W_DATA"},    32'(W_DATA),    0);
  endtask

  // Idle-period check: no enable, no stream, not busy, no DONE.
  task automatic chk_quiet(input string tag, input int n);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      @(negedge CLK);
      if (BRAM_EN || W_VALID || BUSY || DONE) act++;
    end
    chk({tag, " quiet cycles active"}, act, 0);
  endtask

  // One read pass. The expected stream is exp_base+i for i = 0..DEPTH-1,
  // last flag only on the final word, DONE one cycle after the last transfer.
  task automatic run_pass(input string tag, input int mode, input int stall, input bit extra,
                          input int exp_first, input int exp_done, input int abort_after);
    int nx = 0, first = -1, done_k = -1, last_k = -1;
    int rd_all = 0, rd_stall = 0, max_out = 0, stab_err = 0;
    bit stalled = 1'b0, seen_done = 1'b0;
    logic [DW:0] held = '0;
    for (int k = 0; k < 600 && !seen_done; k++) begin
      @(posedge CLK); #1;
      START = (k == 0) || (extra && (k == 5 || k == 15 || k == exp_done));
      case (mode)
        0:       W_READY = 1'b1;
        1:       W_READY = ((k % 4) == 0) || ((k % 4) == 3);
        2:       W_READY = 1'($urandom_range(0, 1));
        default: W_READY = (k >= stall);
      endcase
      @(negedge CLK);
      if (k == 1) chk({tag, " BUSY after START"}, 32'(BUSY), 1);
      if (stalled && (!W_VALID || {W_LAST, W_DATA} != held)) stab_err++;
      if (W_VALID && first < 0) first = k;
      if (BRAM_EN && !BRAM_WE) begin
        rd_all++;
        if (k <= stall) rd_stall++;
      end
      if (rd_all - nx > max_out) max_out = rd_all - nx;
      if (W_VALID && W_READY) begin
        if (nx < DEPTH)
          chk($sformatf("%s word %0d", tag, nx), {W_LAST, W_DATA},
              {nx == DEPTH - 1, exp_base + 16'(nx)});
        else
          chk({tag, " extra word"}, nx + 1, DEPTH);
        nx++;
        last_k = k;
        if (abort_after > 0 && nx == abort_after) return;
      end
      stalled = W_VALID && !W_READY;
      held    = {W_LAST, W_DATA};
      if (DONE) begin
        seen_done = 1'b1;
        done_k    = k;
      end
    end
    chk({tag, " DONE seen"}, 32'(seen_done), 1);
    chk({tag, " word count"}, nx, DEPTH);
    chk({tag, " DONE after last"}, done_k, last_k + 1);
    chk({tag, " first valid cycle"}, first, exp_first);
    if (exp_done >= 0) chk({tag, " DONE cycle"}, done_k, exp_done);
    chk({tag, " stall stability errors"}, stab_err, 0);
    chk({tag, " buffered+inflight<=2"}, 32'(max_out <= 2), 1);
    if (mode == 3) chk({tag, " reads during stall<=2"}, 32'(rd_stall <= 2), 1);
    chk_quiet(tag, 8);
  endtask

`ifdef WEIGHT_LOAD_EN
  task automatic load_pass();
    int i = 0, guard = 0, bad = 0;
    bit got_done = 1'b0;
    @(posedge CLK); #1;
    LD_START = 1'b1;
    START    = 1'b1;
    @(posedge CLK); #1;
    LD_START = 1'b0;
    START    = 1'b0;
    while (i < DEPTH && guard < 400) begin
      LD_VALID = ($urandom_range(0, 2) != 0);
      LD_DATA  = 16'hA000 + 16'(i);
      @(negedge CLK);
      if (LD_VALID && LD_READY) i++;
      @(posedge CLK); #1;
      guard++;
    end
    LD_VALID = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      if (DONE) got_done = 1'b1;
      @(posedge CLK); #1;
    end
    chk("load words accepted", i, DEPTH);
    chk("load DONE seen", 32'(got_done), 1);
    for (int j = 0; j < DEPTH; j++) if (mem[j] != 16'hA000 + 16'(j)) bad++;
    chk("load BRAM contents mismatches", bad, 0);
  endtask
`endif

  initial begin
    vecs[0] = '{0, 0,  1'b0, 2, 30};
    vecs[1] = '{1, 0,  1'b0, 2, -1};
    vecs[2] = '{3, 10, 1'b0, 2, -1};
    vecs[3] = '{2, 0,  1'b0, 2, -1};
    vecs[4] = '{0, 0,  1'b1, 2, 30};
    vecs[5] = '{2, 0,  1'b0, 2, -1};

    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outs("por");
    @(negedge CLK);
    RST_N     = 1'b1;
    bram_init = 1'b0;
    chk_quiet("post-por", 4);

    foreach (vecs[v])
      run_pass($sformatf("vec%0d", v), vecs[v].mode, vecs[v].stall, vecs[v].extra,
               vecs[v].exp_first, vecs[v].exp_done, 0);

    // Reset mid-pass after the 10th transfer, then a clean pass from address 0.
    run_pass("pre-rst", 0, 0, 1'b0, 2, 30, 10);
    START = 1'b0;
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    chk_reset_outs("mid-rst");
    @(posedge CLK); #1;
    chk_reset_outs("mid-rst hold");
    @(negedge CLK);
    RST_N = 1'b1;
    chk_quiet("post-rst", 5);
    run_pass("after-rst", 0, 0, 1'b0, 2, 30, 0);

`ifdef WEIGHT_LOAD_EN
    load_pass();
    exp_base = 16'hA000;
    run_pass("load-read", 0, 0, 1'b0, 2, 30, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
